// File: rtl/key_extract_pkg.sv
// Shared constants and types for the key extraction stage: PHV container
// geometry, selection-table entry layout and control header field offsets.
package key_extract_pkg;

  // Container classes, stored MSB-first in the PHV: 6B, 4B, 2B, then metadata.
  localparam int NUM_CONT  = 8;
  localparam int CW_6B     = 48;
  localparam int CW_4B     = 32;
  localparam int CW_2B     = 16;
  localparam int CONT_BITS = NUM_CONT * (CW_6B + CW_4B + CW_2B);

  // Container index width inside a table entry.
  localparam int IDX_W     = 3;

  // Config id is the low nibble of the vlan id, which sits in metadata.
  localparam int CONF_ID_W = 4;
  localparam int VLAN_LSB  = 129;

  // Selection-table entry: valid flag plus six container indices.
  localparam int ENTRY_W   = 1 + 6 * IDX_W;

  // Key = two of each container class, config id, valid tag bit.
  localparam int KEY_W     = 2 * (CW_6B + CW_4B + CW_2B) + CONF_ID_W + 1;

  // Control header: module id in the low byte, table index in the next nibble.
  localparam int HDR_MOD_LSB = 0;
  localparam int HDR_MOD_W   = 8;
  localparam int HDR_IDX_LSB = 8;

  // Field order matches the in-band write payload bits [18:0].
  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] c6a;
    logic [IDX_W-1:0] c6b;
    logic [IDX_W-1:0] c4a;
    logic [IDX_W-1:0] c4b;
    logic [IDX_W-1:0] c2a;
    logic [IDX_W-1:0] c2b;
  } conf_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_SWALLOW = 2'd2,
    ST_FWD     = 2'd3
  } ctrl_state_e;

  // Module id a control header must carry to address this extractor.
  function automatic logic [HDR_MOD_W-1:0] hdr_mod_id(input logic [4:0] stage,
                                                      input logic [2:0] kid);
    return {stage, kid};
  endfunction

endpackage

// File: rtl/key_extract_ctrl.sv
// Control-chain decoder: swallows packets addressed to this extractor and
// turns their payload into a table write; forwards everything else with one
// register of latency.
module key_extract_ctrl
  import key_extract_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int KEY_ID               = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic                              tbl_wr_en,
  output logic [CONF_ID_W-1:0]              tbl_wr_idx,
  output conf_entry_t                       tbl_wr_data
);

  localparam logic [HDR_MOD_W-1:0] MY_ID = hdr_mod_id(STAGE_ID[4:0], KEY_ID[2:0]);

  ctrl_state_e          state, state_nxt;
  logic                 hdr_match;
  logic                 fwd_beat;
  logic                 idx_ld;
  logic [CONF_ID_W-1:0] wr_idx;

  assign hdr_match   = (c_s_axis_tdata[HDR_MOD_LSB +: HDR_MOD_W] == MY_ID);
  assign tbl_wr_idx  = wr_idx;
  assign tbl_wr_data = conf_entry_t'(c_s_axis_tdata[ENTRY_W-1:0]);

  // State register; reset drops any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, forward decision and table write strobe, evaluated per valid beat.
  always_comb begin
    state_nxt = state;
    fwd_beat  = 1'b0;
    tbl_wr_en = 1'b0;
    idx_ld    = 1'b0;
    if (c_s_axis_tvalid) begin
      case (state)
        ST_IDLE: begin
          if (hdr_match) begin
            // Header-only packets are addressed to us but carry no entry.
            idx_ld = 1'b1;
            if (!c_s_axis_tlast) state_nxt = ST_WRITE;
          end else begin
            fwd_beat = 1'b1;
            if (!c_s_axis_tlast) state_nxt = ST_FWD;
          end
        end
        ST_WRITE: begin
          tbl_wr_en = 1'b1;
          state_nxt = c_s_axis_tlast ? ST_IDLE : ST_SWALLOW;
        end
        ST_SWALLOW: begin
          if (c_s_axis_tlast) state_nxt = ST_IDLE;
        end
        ST_FWD: begin
          fwd_beat = 1'b1;
          if (c_s_axis_tlast) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Latch the target table index from a matching header.
  always_ff @(posedge clk) begin
    if (!rst_n)      wr_idx <= '0;
    else if (idx_ld) wr_idx <= c_s_axis_tdata[HDR_IDX_LSB +: CONF_ID_W];
  end

  // Forwarded beats leave one cycle later with every field registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd_beat;
      c_m_axis_tlast  <= fwd_beat & c_s_axis_tlast;
      if (fwd_beat) begin
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
      end
    end
  end

endmodule

// File: rtl/key_extract_stage.sv
// Per-stage key extractor. S1 registers the PHV with its selection entry,
// S2 registers the assembled key next to the PHV passthrough. Both stages
// advance together and hold under downstream backpressure.
module key_extract_stage
  import key_extract_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int PHV_LEN              = 1024,
  parameter int KEY_LEN              = 197,
  parameter int KEY_ID               = 1,
  parameter int C_VLANID_WIDTH       = 12,
  parameter int CONF_DEPTH           = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_valid_in,
  output logic                              ready_out,
  output logic [KEY_LEN-1:0]                key_out,
  output logic                              key_valid,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_valid_out,
  input  logic                              ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);

  localparam int STAGES  = 2;
  // Config id never exceeds the vlan id it is cut from.
  localparam int CID_W   = (C_VLANID_WIDTH < CONF_ID_W) ? C_VLANID_WIDTH : CONF_ID_W;
  localparam int C2_BASE = PHV_LEN - CONT_BITS;
  localparam int C4_BASE = C2_BASE + NUM_CONT * CW_2B;
  localparam int C6_BASE = C4_BASE + NUM_CONT * CW_4B;

  // Selection table and its write port from the control decoder.
  conf_entry_t          conf_tbl [CONF_DEPTH];
  logic                 tbl_wr_en;
  logic [CONF_ID_W-1:0] tbl_wr_idx;
  conf_entry_t          tbl_wr_data;

  // Pipeline state.
  logic                 adv;
  logic [STAGES:1]      vld_pipe;
  logic [PHV_LEN-1:0]   s1_phv;
  conf_entry_t          s1_ent;
  logic [CID_W-1:0]     in_conf_id;
  logic [CID_W-1:0]     s1_conf_id;
  logic [KEY_LEN-1:0]   key_nxt;

  // Container views of the S1 PHV; element i sits at class base + i*width.
  logic [NUM_CONT-1:0][CW_6B-1:0] c6;
  logic [NUM_CONT-1:0][CW_4B-1:0] c4;
  logic [NUM_CONT-1:0][CW_2B-1:0] c2;

  assign c6 = s1_phv[C6_BASE +: NUM_CONT*CW_6B];
  assign c4 = s1_phv[C4_BASE +: NUM_CONT*CW_4B];
  assign c2 = s1_phv[C2_BASE +: NUM_CONT*CW_2B];

  assign in_conf_id = phv_in[VLAN_LSB +: CID_W];
  assign s1_conf_id = s1_phv[VLAN_LSB +: CID_W];

  // Both stages move only when S2 is empty or being drained downstream.
  assign adv           = ~vld_pipe[STAGES] | ready_in;
  assign ready_out     = adv;
  assign key_valid     = vld_pipe[STAGES];
  assign phv_valid_out = vld_pipe[STAGES];

  key_extract_ctrl #(
    .C_S_AXIS_DATA_WIDTH  (C_S_AXIS_DATA_WIDTH),
    .C_S_AXIS_TUSER_WIDTH (C_S_AXIS_TUSER_WIDTH),
    .STAGE_ID             (STAGE_ID),
    .KEY_ID               (KEY_ID)
  ) u_ctrl (
    .clk             (clk),
    .rst_n           (rst_n),
    .c_s_axis_tdata  (c_s_axis_tdata),
    .c_s_axis_tuser  (c_s_axis_tuser),
    .c_s_axis_tkeep  (c_s_axis_tkeep),
    .c_s_axis_tvalid (c_s_axis_tvalid),
    .c_s_axis_tlast  (c_s_axis_tlast),
    .c_m_axis_tdata  (c_m_axis_tdata),
    .c_m_axis_tuser  (c_m_axis_tuser),
    .c_m_axis_tkeep  (c_m_axis_tkeep),
    .c_m_axis_tvalid (c_m_axis_tvalid),
    .c_m_axis_tlast  (c_m_axis_tlast),
    .tbl_wr_en       (tbl_wr_en),
    .tbl_wr_idx      (tbl_wr_idx),
    .tbl_wr_data     (tbl_wr_data)
  );

  // Table write; an S1 read of the same entry in this cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CONF_DEPTH; i++) conf_tbl[i] <= '0;
    end else if (tbl_wr_en) begin
      conf_tbl[tbl_wr_idx] <= tbl_wr_data;
    end
  end

  // S1: capture PHV, its valid and the selection entry for its config id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_phv      <= '0;
      s1_ent      <= '0;
    end else if (adv) begin
      vld_pipe[1] <= phv_valid_in;
      s1_phv      <= phv_in;
      s1_ent      <= conf_tbl[in_conf_id];
    end
  end

  // Key assembly; an invalid entry still yields the config id tag.
  always_comb begin
    key_nxt = '0;
    key_nxt[CID_W:1] = s1_conf_id;
    if (s1_ent.vld) begin
      key_nxt = {c6[s1_ent.c6a], c6[s1_ent.c6b],
                 c4[s1_ent.c4a], c4[s1_ent.c4b],
                 c2[s1_ent.c2a], c2[s1_ent.c2b],
                 s1_conf_id, 1'b1};
    end
  end

  // S2: register key and PHV passthrough together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      key_out     <= '0;
      phv_out     <= '0;
    end else if (adv) begin
      vld_pipe[2] <= vld_pipe[1];
      key_out     <= key_nxt;
      phv_out     <= s1_phv;
    end
  end

endmodule
